avalon_pkt_buffer: RTL and testbench
====================================

// Module: avalon_pkt_buffer
// PURPOSE
//  Store-and-forward Avalon-ST packet buffer placed directly upstream of the packet sorter.
//  - Accepts raw Avalon-ST beats and holds each packet until it is complete and well-formed.
//  - Presents only whole packets of 1..MAX_PKT_LEN words downstream, so the sorter never sees partial packets.
//  - Discards malformed or over-length packets and counts them.
// PARAMETERS
//  DWIDTH      4  data width, bits
//  MAX_PKT_LEN 5  max words per packet; must match the downstream sorter
//  NUM_SLOTS   2  packet slots, each MAX_PKT_LEN words deep
//  ERR_W       8  width of the error counter
// PORTS
//  clk_i                input   1       single clock
//  srst_i               input   1       synchronous reset, active-high
//  snk_data_i           input   DWIDTH  input beat data
//  snk_valid_i          input   1       input beat valid
//  snk_startofpacket_i  input   1       first beat of a packet
//  snk_endofpacket_i    input   1       last beat of a packet
//  snk_ready_o          output  1       buffer can accept a beat this cycle
//  src_data_o           output  DWIDTH  output beat data
//  src_valid_o          output  1       output beat valid
//  src_startofpacket_o  output  1       first output word
//  src_endofpacket_o    output  1       last output word
//  src_ready_i          input   1       downstream accepts the beat
//  err_cnt_o            output  ERR_W   count of dropped packets and stray beats; saturating
// BEHAVIOUR
//  Interface decisions (fixed):
//  - One clock. Reset is synchronous and active-high: clk_i, srst_i.
//  Reset:
//  - All registered outputs go to 0: src_*, snk_ready_o, err_cnt_o.
//  - All slots are freed. Any packet in flight on either side is lost, with no error count.
//  - snk_ready_o rises on the first cycle after srst_i deasserts.
//  Handshakes:
//  - Input beat is taken when snk_valid_i && snk_ready_o.
//  - Output beat transfers when src_valid_o && src_ready_i.
//  - While src_ready_i is low, all src_* outputs hold stable.
//  Write FSM:
//  - IDLE: taken beat with SOP -> FILL, word 0 written into the free slot. Taken beat without SOP -> err+1, discarded, stay IDLE.
//  - FILL:
//    - SOP without EOP -> restart same slot at word 0; err+1 for the aborted packet.
//    - SOP with EOP in FILL -> aborted packet err+1; the 1-word packet commits; -> IDLE.
//    - Beat number MAX_PKT_LEN+1 -> DROP, slot discarded, err+1. If that beat carries EOP, go straight to IDLE.
//    - EOP -> commit slot with length 1..MAX_PKT_LEN -> IDLE.
//    - SOP+EOP on one beat from IDLE -> 1-word packet, commits immediately.
//  - DROP: accept and discard beats until EOP -> IDLE.
//  - snk_ready_o is a register:
//    - 1 in FILL or DROP.
//    - In IDLE, 1 only if a free slot exists after this cycle's commit/free.
//    - When the last free slot commits, ready is 0 the next cycle.
//  Read side:
//  - Slots are served in commit order.
//  - Earliest first output: EOP taken at edge N -> src_valid_o=1 after edge N+1.
//  - Within a packet: 1 word/cycle while src_ready_i=1.
//  - At most 1 idle cycle between consecutive packets.
//  - src_startofpacket_o=1 on word 0. src_endofpacket_o=1 on word len-1; both are set for a 1-word packet.
//  - Slot is freed on the edge where its EOP beat transfers.
//  Counters and arithmetic:
//  - Occupied-slot counter is [$clog2(NUM_SLOTS):0]. Commit and free on the same edge leave it unchanged.
//  - Read/write slot indices wrap NUM_SLOTS-1 -> 0.
//  - Word index is [$clog2(MAX_PKT_LEN):0] so MAX_PKT_LEN+1 is detectable.
//  - err_cnt_o saturates at all-ones.
// STRUCTURE
//  - Package avalon_pkt_pkg:
//    - wr_state_t enum {WR_IDLE_S, WR_FILL_S, WR_DROP_S}
//    - rd_state_t enum {RD_IDLE_S, RD_SEND_S}
//  - Sub-module pkt_slot_mem: NUM_SLOTS x MAX_PKT_LEN x DWIDTH array with per-slot length register.
//    - 1 write port, 1 registered read port.
//  - Top level: write FSM, read FSM, slot occupancy counter, err counter.
// TESTING
//  - Packet 3,1,2 (SOP on 3, EOP on 2), src_ready_i=1 -> 3,1,2 out: SOP on 3, EOP on 2, first valid 2 cycles after EOP in; err=0.
//  - 1-word packet with SOP+EOP on value 7 -> single out beat 7 with SOP=EOP=1.
//  - 6-word packet (MAX_PKT_LEN=5) then a 2-word packet 4,9 -> only 4,9 out; err_cnt_o=1.
//  - Beat without SOP in IDLE, then SOP mid-packet -> err_cnt_o=2; the restarted packet is delivered intact.
//  - Hold src_ready_i=0, send 3 packets (NUM_SLOTS=2) -> snk_ready_o drops after 2nd EOP. Release -> packets out in order, no loss.
//  - srst_i pulse mid-output -> src_valid_o=0 the next cycle, slots empty, snk_ready_o=1 after reset; a fresh packet passes normally.

Source files
------------

// File: rtl/avalon_pkt_pkg.sv
// Shared types for the Avalon-ST store-and-forward packet buffer.
package avalon_pkt_pkg;

   typedef enum logic [1:0] {
      WR_IDLE_S = 2'd0,
      WR_FILL_S = 2'd1,
      WR_DROP_S = 2'd2
   } wr_state_t;

   typedef enum logic {
      RD_IDLE_S = 1'b0,
      RD_SEND_S = 1'b1
   } rd_state_t;

endpackage

// File: rtl/pkt_slot_mem.sv
// Packet slot storage: NUM_SLOTS x MAX_PKT_LEN words plus a committed length per slot.
// One write port, one registered read port; the read register holds when not enabled.
module pkt_slot_mem #(
   parameter int DWIDTH      = 4,
   parameter int MAX_PKT_LEN = 5,
   parameter int NUM_SLOTS   = 2,
   parameter int SLOT_W      = 1,
   parameter int WORD_W      = 3,
   parameter int LEN_W       = 4
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wr_en_i,
   input  logic [SLOT_W-1:0] wr_slot_i,
   input  logic [WORD_W-1:0] wr_word_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   input  logic              len_we_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              rd_en_i,
   input  logic [SLOT_W-1:0] rd_slot_i,
   input  logic [WORD_W-1:0] rd_word_i,
   output logic [DWIDTH-1:0] rd_data_o,
   output logic [LEN_W-1:0]  rd_len_o
);

   logic [DWIDTH-1:0] mem_q [NUM_SLOTS][MAX_PKT_LEN];
   logic [LEN_W-1:0]  len_q [NUM_SLOTS];
   logic [DWIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_slot_i][wr_word_i] <= wr_data_i;
      end
      if (len_we_i) begin
         len_q[wr_slot_i] <= len_i;
      end
   end

   // The read register drives the source data port directly, so it is reset.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_slot_i][rd_word_i];
      end
   end

   assign rd_data_o = rd_data_q;
   assign rd_len_o  = len_q[rd_slot_i];

endmodule

// File: rtl/avalon_pkt_buffer.sv
// Store-and-forward Avalon-ST buffer: only complete packets of 1..MAX_PKT_LEN words
// are forwarded; stray beats, aborted and over-length packets are dropped and counted.
module avalon_pkt_buffer
   import avalon_pkt_pkg::*;
#(
   parameter int DWIDTH      = 4,
   parameter int MAX_PKT_LEN = 5,
   parameter int NUM_SLOTS   = 2,
   parameter int ERR_W       = 8
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] snk_data_i,
   input  logic              snk_valid_i,
   input  logic              snk_startofpacket_i,
   input  logic              snk_endofpacket_i,
   output logic              snk_ready_o,
   output logic [DWIDTH-1:0] src_data_o,
   output logic              src_valid_o,
   output logic              src_startofpacket_o,
   output logic              src_endofpacket_o,
   input  logic              src_ready_i,
   output logic [ERR_W-1:0]  err_cnt_o
);

   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int WORD_W = $clog2(MAX_PKT_LEN);
   localparam int IDX_W  = $clog2(MAX_PKT_LEN) + 1;
   localparam int OCC_W  = $clog2(NUM_SLOTS) + 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
   localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(MAX_PKT_LEN);
   localparam logic [IDX_W-1:0]  ONE_IDX   = IDX_W'(1);
   localparam logic [OCC_W-1:0]  NUM_OCC   = OCC_W'(NUM_SLOTS);

   wr_state_t         wr_state_q, wr_state_d;
   rd_state_t         rd_state_q, rd_state_d;
   logic [SLOT_W-1:0] wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              snk_ready_q, snk_ready_d;
   logic              src_valid_q, src_valid_d;
   logic              src_sop_q, src_sop_d, src_eop_q, src_eop_d;

   logic              take, commit, free, err_inc, mem_we, rd_en;
   logic [WORD_W-1:0] mem_wword, rd_word;
   logic [IDX_W-1:0]  commit_len, rd_len;

   function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
      return (s == LAST_SLOT) ? '0 : s + SLOT_W'(1);
   endfunction

   assign take = snk_valid_i && snk_ready_q;

   always_comb begin
      wr_state_d = wr_state_q;
      wr_slot_d  = wr_slot_q;
      wr_idx_d   = wr_idx_q;
      mem_we     = 1'b0;
      mem_wword  = wr_idx_q[WORD_W-1:0];
      commit     = 1'b0;
      commit_len = wr_idx_q + ONE_IDX;
      err_inc    = 1'b0;
      if (take) begin
         case (wr_state_q)
            WR_IDLE_S, WR_FILL_S: begin
               if (snk_startofpacket_i) begin
                  // A SOP inside FILL aborts the packet in progress; the slot restarts.
                  err_inc   = (wr_state_q == WR_FILL_S);
                  mem_we    = 1'b1;
                  mem_wword = '0;
                  if (snk_endofpacket_i) begin
                     commit     = 1'b1;
                     commit_len = ONE_IDX;
                     wr_state_d = WR_IDLE_S;
                  end else begin
                     wr_idx_d   = ONE_IDX;
                     wr_state_d = WR_FILL_S;
                  end
               end else if (wr_state_q == WR_IDLE_S) begin
                  err_inc = 1'b1;
               end else if (wr_idx_q == MAX_IDX) begin
                  err_inc    = 1'b1;
                  wr_state_d = snk_endofpacket_i ? WR_IDLE_S : WR_DROP_S;
               end else begin
                  mem_we = 1'b1;
                  if (snk_endofpacket_i) begin
                     commit     = 1'b1;
                     wr_state_d = WR_IDLE_S;
                  end else begin
                     wr_idx_d = wr_idx_q + ONE_IDX;
                  end
               end
            end
            WR_DROP_S: begin
               if (snk_endofpacket_i) begin
                  wr_state_d = WR_IDLE_S;
               end
            end
            default: wr_state_d = WR_IDLE_S;
         endcase
      end
      if (commit) begin
         wr_slot_d = next_slot(wr_slot_q);
      end
   end

   // The output registers only advance while downstream accepts, so src_* hold otherwise.
   always_comb begin
      rd_state_d  = rd_state_q;
      rd_slot_d   = rd_slot_q;
      rd_idx_d    = rd_idx_q;
      src_valid_d = src_valid_q;
      src_sop_d   = src_sop_q;
      src_eop_d   = src_eop_q;
      rd_en       = 1'b0;
      rd_word     = rd_idx_q[WORD_W-1:0];
      free        = 1'b0;
      case (rd_state_q)
         RD_IDLE_S: begin
            if (occ_q != '0) begin
               rd_en       = 1'b1;
               rd_word     = '0;
               src_valid_d = 1'b1;
               src_sop_d   = 1'b1;
               src_eop_d   = (rd_len == ONE_IDX);
               rd_idx_d    = ONE_IDX;
               rd_state_d  = RD_SEND_S;
            end
         end
         RD_SEND_S: begin
            if (src_ready_i) begin
               if (src_eop_q) begin
                  free        = 1'b1;
                  src_valid_d = 1'b0;
                  src_sop_d   = 1'b0;
                  src_eop_d   = 1'b0;
                  rd_slot_d   = next_slot(rd_slot_q);
                  rd_state_d  = RD_IDLE_S;
               end else begin
                  rd_en       = 1'b1;
                  src_valid_d = 1'b1;
                  src_sop_d   = 1'b0;
                  src_eop_d   = (rd_idx_q == rd_len - ONE_IDX);
                  rd_idx_d    = rd_idx_q + ONE_IDX;
               end
            end
         end
         default: rd_state_d = RD_IDLE_S;
      endcase
   end

   always_comb begin
      occ_d       = occ_q + OCC_W'(commit) - OCC_W'(free);
      snk_ready_d = (wr_state_d != WR_IDLE_S) || (occ_d < NUM_OCC);
      err_d       = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_state_q  <= WR_IDLE_S;
         rd_state_q  <= RD_IDLE_S;
         wr_slot_q   <= '0;
         rd_slot_q   <= '0;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         occ_q       <= '0;
         err_q       <= '0;
         snk_ready_q <= 1'b0;
         src_valid_q <= 1'b0;
         src_sop_q   <= 1'b0;
         src_eop_q   <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         wr_slot_q   <= wr_slot_d;
         rd_slot_q   <= rd_slot_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         occ_q       <= occ_d;
         err_q       <= err_d;
         snk_ready_q <= snk_ready_d;
         src_valid_q <= src_valid_d;
         src_sop_q   <= src_sop_d;
         src_eop_q   <= src_eop_d;
      end
   end

   pkt_slot_mem #(
      .DWIDTH      (DWIDTH),
      .MAX_PKT_LEN (MAX_PKT_LEN),
      .NUM_SLOTS   (NUM_SLOTS),
      .SLOT_W      (SLOT_W),
      .WORD_W      (WORD_W),
      .LEN_W       (IDX_W)
   ) u_mem (
      .clk_i     (clk_i),
      .srst_i    (srst_i),
      .wr_en_i   (mem_we),
      .wr_slot_i (wr_slot_q),
      .wr_word_i (mem_wword),
      .wr_data_i (snk_data_i),
      .len_we_i  (commit),
      .len_i     (commit_len),
      .rd_en_i   (rd_en),
      .rd_slot_i (rd_slot_q),
      .rd_word_i (rd_word),
      .rd_data_o (src_data_o),
      .rd_len_o  (rd_len)
   );

   assign snk_ready_o         = snk_ready_q;
   assign src_valid_o         = src_valid_q;
   assign src_startofpacket_o = src_sop_q;
   assign src_endofpacket_o   = src_eop_q;
   assign err_cnt_o           = err_q;

endmodule

// File: tb/tb_avalon_pkt_buffer.sv
// Scoreboard bench for avalon_pkt_buffer: stimulus pushes expected output beats,
// a negedge monitor pops and compares every transferred beat.
module tb_avalon_pkt_buffer;

   logic       clk_i = 1'b0;
   logic       srst_i = 1'b1;
   logic [3:0] snk_data_i = '0;
   logic       snk_valid_i = 1'b0;
   logic       snk_startofpacket_i = 1'b0;
   logic       snk_endofpacket_i = 1'b0;
   logic       snk_ready_o;
   logic [3:0] src_data_o;
   logic       src_valid_o;
   logic       src_startofpacket_o;
   logic       src_endofpacket_o;
   logic       src_ready_i = 1'b0;
   logic [7:0] err_cnt_o;

   typedef struct {
      logic [3:0] d;
      logic       s;
      logic       e;
   } beat_t;

   beat_t exp_q[$];
   int    total = 0;
   int    bad = 0;

   always #5 clk_i = ~clk_i;

   avalon_pkt_buffer dut (
      .clk_i               (clk_i),
      .srst_i              (srst_i),
      .snk_data_i          (snk_data_i),
      .snk_valid_i         (snk_valid_i),
      .snk_startofpacket_i (snk_startofpacket_i),
      .snk_endofpacket_i   (snk_endofpacket_i),
      .snk_ready_o         (snk_ready_o),
      .src_data_o          (src_data_o),
      .src_valid_o         (src_valid_o),
      .src_startofpacket_o (src_startofpacket_o),
      .src_endofpacket_o   (src_endofpacket_o),
      .src_ready_i         (src_ready_i),
      .err_cnt_o           (err_cnt_o)
   );

   // Monitor: one line per output transaction.
   always @(negedge clk_i) begin
      if (!srst_i && src_valid_o && src_ready_i) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL out_beat: unexpected beat d=%0h sop=%0b eop=%0b", src_data_o,
                     src_startofpacket_o, src_endofpacket_o);
         end else begin
            beat_t b;
            b = exp_q.pop_front();
            if (src_data_o !== b.d || src_startofpacket_o !== b.s || src_endofpacket_o !== b.e) begin
               bad++;
               $display("FAIL out_beat: got d=%0h sop=%0b eop=%0b expected d=%0h sop=%0b eop=%0b",
                        src_data_o, src_startofpacket_o, src_endofpacket_o, b.d, b.s, b.e);
            end else begin
               $display("out beat d=%0h sop=%0b eop=%0b ok", src_data_o, src_startofpacket_o,
                        src_endofpacket_o);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic push_exp(input logic [3:0] d, input logic s, input logic e);
      beat_t b;
      b.d = d;
      b.s = s;
      b.e = e;
      exp_q.push_back(b);
   endtask

   // Called at posedge+1; returns at posedge+1 after the edge that took the beat.
   task automatic send_beat(input logic [3:0] d, input logic s, input logic e);
      int n;
      n = 0;
      snk_data_i = d;
      snk_valid_i = 1'b1;
      snk_startofpacket_i = s;
      snk_endofpacket_i = e;
      @(negedge clk_i);
      while (!snk_ready_o && n < 300) begin
         n++;
         @(negedge clk_i);
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL snk_timeout: got ready=0 expected ready=1 within 300 cycles");
      end
      @(posedge clk_i);
      #1;
      snk_valid_i = 1'b0;
      snk_startofpacket_i = 1'b0;
      snk_endofpacket_i = 1'b0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || src_valid_o) && n < 300) begin
         tick(1);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      srst_i = 1'b1;
      exp_q.delete();
      tick(2);
      srst_i = 1'b0;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick(3);
      check("rst_src_valid", src_valid_o, 0);
      check("rst_snk_ready", snk_ready_o, 0);
      check("rst_err", err_cnt_o, 0);
      check("rst_sop_eop", {src_startofpacket_o, src_endofpacket_o}, 0);
      srst_i = 1'b0;
      check("ready_at_deassert", snk_ready_o, 0);
      tick(1);
      check("ready_after_rst", snk_ready_o, 1);

      // 3-word packet and first-output latency
      src_ready_i = 1'b1;
      push_exp(4'h3, 1, 0); push_exp(4'h1, 0, 0); push_exp(4'h2, 0, 1);
      send_beat(4'h3, 1, 0);
      send_beat(4'h1, 0, 0);
      send_beat(4'h2, 0, 1);
      check("lat_valid_edge_n", src_valid_o, 0);
      tick(1);
      check("lat_valid_edge_n1", src_valid_o, 1);
      drain();
      check("err_after_pkt1", err_cnt_o, 0);

      // 1-word packet
      push_exp(4'h7, 1, 1);
      send_beat(4'h7, 1, 1);
      drain();

      // Exactly MAX_PKT_LEN words is delivered
      for (int i = 1; i <= 5; i++) begin
         push_exp(4'(i), i == 1, i == 5);
         send_beat(4'(i), i == 1, i == 5);
      end
      drain();
      check("err_after_max_len", err_cnt_o, 0);

      // 6-word packet dropped, then 4,9 delivered
      for (int i = 1; i <= 6; i++) begin
         send_beat(4'(i + 8), i == 1, i == 6);
      end
      push_exp(4'h4, 1, 0); push_exp(4'h9, 0, 1);
      send_beat(4'h4, 1, 0);
      send_beat(4'h9, 0, 1);
      drain();
      check("err_overlen", err_cnt_o, 1);

      // Stray beat, then SOP mid-packet restart
      do_reset();
      check("err_cleared", err_cnt_o, 0);
      send_beat(4'h5, 0, 0);
      send_beat(4'h8, 1, 0);
      send_beat(4'h6, 0, 0);
      push_exp(4'h1, 1, 0); push_exp(4'h2, 0, 0); push_exp(4'h3, 0, 1);
      send_beat(4'h1, 1, 0);
      send_beat(4'h2, 0, 0);
      send_beat(4'h3, 0, 1);
      drain();
      check("err_stray_abort", err_cnt_o, 2);

      // Backpressure with both slots full
      src_ready_i = 1'b0;
      push_exp(4'hA, 1, 0); push_exp(4'hB, 0, 1);
      push_exp(4'hC, 1, 1);
      push_exp(4'hD, 1, 0); push_exp(4'hE, 0, 1);
      send_beat(4'hA, 1, 0);
      send_beat(4'hB, 0, 1);
      send_beat(4'hC, 1, 1);
      check("full_ready_drop", snk_ready_o, 0);
      tick(3);
      check("full_ready_hold", snk_ready_o, 0);
      check("hold_beat", {src_valid_o, src_startofpacket_o, src_endofpacket_o, src_data_o},
            {3'b110, 4'hA});
      src_ready_i = 1'b1;
      send_beat(4'hD, 1, 0);
      send_beat(4'hE, 0, 1);
      drain();
      check("err_backpressure", err_cnt_o, 2);

      // Reset in the middle of an outgoing packet
      push_exp(4'h1, 1, 0); push_exp(4'h2, 0, 0); push_exp(4'h3, 0, 0);
      push_exp(4'h4, 0, 0); push_exp(4'h5, 0, 1);
      for (int i = 1; i <= 5; i++) begin
         send_beat(4'(i), i == 1, i == 5);
      end
      tick(2);
      srst_i = 1'b1;
      exp_q.delete();
      tick(1);
      check("midrst_valid", src_valid_o, 0);
      srst_i = 1'b0;
      tick(1);
      check("midrst_ready", snk_ready_o, 1);
      check("midrst_err", err_cnt_o, 0);
      tick(3);
      check("midrst_empty", src_valid_o, 0);
      push_exp(4'h6, 1, 0); push_exp(4'h5, 0, 1);
      send_beat(4'h6, 1, 0);
      send_beat(4'h5, 0, 1);
      drain();
      check("err_final", err_cnt_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
